// File: rtl/vga_pkg.sv
// Shared timing constants, winner encoding and colour definitions for the VGA ball renderer.
package vga_pkg;

    localparam int unsigned PIX_DIV   = 4;
    localparam int unsigned H_VIS     = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_VIS     = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned BALL_SIZE = 8;

    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    // Counter width covers both 0..799 and 0..524.
    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        WinNone = 2'd0,
        WinP1   = 2'd1,
        WinP2   = 2'd2,
        WinRsvd = 2'd3
    } winner_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t RGB_BALL  = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb_t BG_NONE   = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t BG_P1     = '{r: 4'h8, g: 4'h0, b: 4'h0};
    localparam rgb_t BG_P2     = '{r: 4'h0, g: 4'h0, b: 4'h8};

    function automatic rgb_t bg_colour(input winner_e w);
        rgb_t c;
        unique case (w)
            WinP1:            c = BG_P1;
            WinP2:            c = BG_P2;
            WinNone, WinRsvd: c = BG_NONE;
            default:          c = BG_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_ball_renderer_if.sv
// Game-register inputs and VGA port outputs of the ball renderer.
interface vga_ball_renderer_if;

    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [1:0] winner;
    logic [9:0] ball_xlim;
    logic [8:0] ball_ylim;
    logic       hsync;
    logic       vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_tick;

    // Regfile / display side.
    modport master (
        output ball_x, ball_y, winner,
        input  ball_xlim, ball_ylim, hsync, vsync, vga_r, vga_g, vga_b, frame_tick
    );

    // Renderer side.
    modport slave (
        input  ball_x, ball_y, winner,
        output ball_xlim, ball_ylim, hsync, vsync, vga_r, vga_g, vga_b, frame_tick
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v raster counters, registered sync outputs and per-frame snapshot strobe.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = vga_pkg::PIX_DIV,
    parameter int unsigned H_VIS   = vga_pkg::H_VIS,
    parameter int unsigned H_FP    = vga_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_pkg::H_BP,
    parameter int unsigned V_VIS   = vga_pkg::V_VIS,
    parameter int unsigned V_FP    = vga_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_pkg::V_BP
) (
    input  logic             clock,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             visible,
    output logic             snap,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_tick
);

    localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_VIS + H_FP;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VIS + V_FP;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             tick_q;
    logic             h_last;
    logic             v_last;
    logic             in_hs;
    logic             in_vs;

    assign pix_en  = (div_q == DIV_W'(PIX_DIV - 1));
    assign h_last  = (h_q == CNT_W'(H_TOT - 1));
    assign v_last  = (v_q == CNT_W'(V_TOT - 1));
    assign in_hs   = (h_q >= CNT_W'(HS_FIRST)) && (h_q <= CNT_W'(HS_LAST));
    assign in_vs   = (v_q >= CNT_W'(VS_FIRST)) && (v_q <= CNT_W'(VS_LAST));
    assign visible = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
    // First pixel of the first blanking line: safe point to sample new game state.
    assign snap    = pix_en && (h_q == '0) && (v_q == CNT_W'(V_VIS));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= snap;
            if (pix_en) begin
                div_q   <= '0;
                hsync_q <= !in_hs;
                vsync_q <= !in_vs;
                h_q     <= h_last ? '0 : h_q + CNT_W'(1);
                if (h_last) begin
                    v_q <= v_last ? '0 : v_q + CNT_W'(1);
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign h          = h_q;
    assign v          = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = tick_q;

endmodule

// File: rtl/vga_ball_renderer.sv
// VGA ball renderer: frame-latched game state, ball hit test and registered colour output.
module vga_ball_renderer
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV   = vga_pkg::PIX_DIV,
    parameter int unsigned H_VIS     = vga_pkg::H_VIS,
    parameter int unsigned H_FP      = vga_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_pkg::H_BP,
    parameter int unsigned V_VIS     = vga_pkg::V_VIS,
    parameter int unsigned V_FP      = vga_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_pkg::V_BP,
    parameter int unsigned BALL_SIZE = vga_pkg::BALL_SIZE
) (
    input logic                clock,
    input logic                reset,
    vga_ball_renderer_if.slave bus
);

    logic             pix_en;
    logic             visible;
    logic             snap;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    logic [9:0] sx_q;
    logic [8:0] sy_q;
    winner_e    sw_q;
    rgb_t       rgb_q;
    rgb_t       pix_rgb;

    logic [10:0] hx;
    logic [10:0] vx;
    logic [10:0] x0;
    logic [10:0] y0;
    logic        in_ball;

    vga_timing #(
        .PIX_DIV (PIX_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
        .pix_en     (pix_en),
        .h          (h),
        .v          (v),
        .visible    (visible),
        .snap       (snap),
        .hsync      (bus.hsync),
        .vsync      (bus.vsync),
        .frame_tick (bus.frame_tick)
    );

    assign bus.ball_xlim = 10'(H_VIS - BALL_SIZE);
    assign bus.ball_ylim = 9'(V_VIS - BALL_SIZE);

    // 11-bit compares so a ball near the right/bottom edge cannot wrap to column/row 0.
    assign hx      = {1'b0, h};
    assign vx      = {1'b0, v};
    assign x0      = {1'b0, sx_q};
    assign y0      = {2'b0, sy_q};
    assign in_ball = (hx >= x0) && (hx < x0 + 11'(BALL_SIZE)) &&
                     (vx >= y0) && (vx < y0 + 11'(BALL_SIZE));

    always_comb begin
        pix_rgb = RGB_BLACK;
        if (visible) begin
            pix_rgb = in_ball ? RGB_BALL : bg_colour(sw_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sx_q  <= '0;
            sy_q  <= '0;
            sw_q  <= WinNone;
            rgb_q <= RGB_BLACK;
        end else begin
            if (snap) begin
                sx_q <= bus.ball_x;
                sy_q <= bus.ball_y;
                sw_q <= winner_e'(bus.winner);
            end
            if (pix_en) begin
                rgb_q <= pix_rgb;
            end
        end
    end

    assign bus.vga_r = rgb_q.r;
    assign bus.vga_g = rgb_q.g;
    assign bus.vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_ball_renderer.sv
// Bench: full-size instance for reset/line timing, reduced-raster instance for frame-level behaviour.
module tb_vga_ball_renderer;

    // Reduced raster: 24 pixels x 18 lines, 4 clocks per pixel.
    localparam int SH     = 24;
    localparam int SFRAME = 24 * 18;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges    = 0;

    always #5 clock = ~clock;

    vga_ball_renderer_if big_if ();
    vga_ball_renderer_if small_if ();

    vga_ball_renderer u_big (
        .clock (clock),
        .reset (reset),
        .bus   (big_if)
    );

    vga_ball_renderer #(
        .PIX_DIV   (4),
        .H_VIS     (16),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (3),
        .V_VIS     (12),
        .V_FP      (2),
        .V_SYNC    (2),
        .V_BP      (2),
        .BALL_SIZE (4)
    ) u_small (
        .clock (clock),
        .reset (reset),
        .bus   (small_if)
    );

    typedef struct {
        bit          do_set;
        int          bx;
        int          by;
        int          bw;
        int          f;
        int          h;
        int          v;
        logic [11:0] rgb;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit do_set, input int bx, input int by, input int bw,
                                input int f, input int h, input int v, input logic [11:0] rgb,
                                input string name);
        vec_t r;
        r.do_set = do_set;
        r.bx     = bx;
        r.by     = by;
        r.bw     = bw;
        r.f      = f;
        r.h      = h;
        r.v      = v;
        r.rgb    = rgb;
        r.name   = name;
        return r;
    endfunction

    function automatic int pix_edge(input int f, input int h, input int v);
        return 4 * (f * SFRAME + v * SH + h + 1);
    endfunction

    function automatic logic [11:0] small_rgb();
        return {small_if.vga_r, small_if.vga_g, small_if.vga_b};
    endfunction

    function automatic logic [11:0] big_rgb();
        return {big_if.vga_r, big_if.vga_g, big_if.vga_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic advance_to(input int target);
        while (edges < target) begin
            @(negedge clock);
            edges++;
        end
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        edges = 0;
    endtask

    initial begin
        int fall1;
        int fall2;
        int hs_low;
        int vs_low;
        int tick1;
        int tick2;
        int tick_cnt;
        int vs_fall;
        logic prev;

        reset = 1'b1;
        big_if.ball_x   = 10'd100;
        big_if.ball_y   = 9'd50;
        big_if.winner   = 2'd0;
        small_if.ball_x = 10'd0;
        small_if.ball_y = 9'd0;
        small_if.winner = 2'd0;
        #1 reset = 1'b0;

        // Reset state and constant limits.
        repeat (5) @(negedge clock);
        check("rst_hsync", 32'(big_if.hsync), 32'd1);
        check("rst_vsync", 32'(big_if.vsync), 32'd1);
        check("rst_rgb", 32'(big_rgb()), 32'h000);
        check("rst_tick", 32'(big_if.frame_tick), 32'd0);
        check("rst_xlim", 32'(big_if.ball_xlim), 32'd632);
        check("rst_ylim", 32'(big_if.ball_ylim), 32'd472);
        check("small_xlim", 32'(small_if.ball_xlim), 32'd12);
        check("small_ylim", 32'(small_if.ball_ylim), 32'd8);
        hold_reset();

        // First pixel enable lands on the 4th edge: pixel (0,0) with zero shadows is ball.
        advance_to(3);
        check("big_pre_pix_en", 32'(big_rgb()), 32'h000);
        advance_to(4);
        check("big_first_pix", 32'(big_rgb()), 32'hFFF);
        advance_to(32);
        check("big_pix7", 32'(big_rgb()), 32'hFFF);
        advance_to(36);
        check("big_pix8", 32'(big_rgb()), 32'h000);

        // Line timing over two lines.
        prev   = big_if.hsync;
        fall1  = -1;
        fall2  = -1;
        hs_low = 0;
        vs_low = 0;
        for (int e = 37; e <= 6400; e++) begin
            advance_to(e);
            if (!big_if.hsync) hs_low++;
            if (!big_if.vsync) vs_low++;
            if (prev && !big_if.hsync) begin
                if (fall1 < 0) fall1 = e;
                else if (fall2 < 0) fall2 = e;
            end
            prev = big_if.hsync;
        end
        check("hsync_fall1", 32'(fall1), 32'd2628);
        check("hsync_fall2", 32'(fall2), 32'd5828);
        check("hsync_low_clks", 32'(hs_low), 32'd768);
        check("vsync_idle", 32'(vs_low), 32'd0);
        check("xlim_run", 32'(big_if.ball_xlim), 32'd632);

        // Frame-level behaviour on the reduced raster.
        hold_reset();
        vecs.push_back(mk(1, 5, 3, 0,   0, 0, 0,   12'hFFF, "f0_origin"));
        vecs.push_back(mk(0, 0, 0, 0,   0, 3, 3,   12'hFFF, "f0_ball_corner"));
        vecs.push_back(mk(0, 0, 0, 0,   0, 5, 3,   12'h000, "f0_no_new_ball"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 5, 2,   12'h000, "f1_above"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 4, 3,   12'h000, "f1_left"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 5, 3,   12'hFFF, "f1_topleft"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 9, 3,   12'h000, "f1_right"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 8, 4,   12'hFFF, "f1_inner"));
        vecs.push_back(mk(1, 10, 3, 1,  1, 5, 6,   12'hFFF, "f1_iso_old_x"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 8, 6,   12'hFFF, "f1_botright"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 10, 6,  12'h000, "f1_iso_new_x"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 5, 7,   12'h000, "f1_below"));
        vecs.push_back(mk(0, 0, 0, 0,   1, 0, 10,  12'h000, "f1_iso_bg"));
        vecs.push_back(mk(0, 0, 0, 0,   2, 0, 0,   12'h800, "f2_bg_p1"));
        vecs.push_back(mk(0, 0, 0, 0,   2, 5, 3,   12'h800, "f2_old_pos"));
        vecs.push_back(mk(0, 0, 0, 0,   2, 10, 3,  12'hFFF, "f2_new_pos"));
        vecs.push_back(mk(0, 0, 0, 0,   2, 13, 6,  12'hFFF, "f2_new_corner"));
        vecs.push_back(mk(0, 0, 0, 0,   2, 14, 6,  12'h800, "f2_past_ball"));
        vecs.push_back(mk(1, 10, 3, 2,  2, 0, 11,  12'h800, "f2_iso_winner"));
        vecs.push_back(mk(0, 0, 0, 0,   3, 0, 0,   12'h008, "f3_bg_p2"));
        vecs.push_back(mk(0, 0, 0, 0,   3, 10, 3,  12'hFFF, "f3_ball"));
        vecs.push_back(mk(1, 14, 10, 3, 3, 0, 11,  12'h008, "f3_iso_bg"));
        vecs.push_back(mk(0, 0, 0, 0,   4, 0, 3,   12'h000, "f4_bg_rsvd"));
        vecs.push_back(mk(0, 0, 0, 0,   4, 13, 10, 12'h000, "f4_left_of_clip"));
        vecs.push_back(mk(0, 0, 0, 0,   4, 14, 10, 12'hFFF, "f4_clip_ball"));
        vecs.push_back(mk(0, 0, 0, 0,   4, 16, 10, 12'h000, "f4_clip_h"));
        vecs.push_back(mk(0, 0, 0, 0,   4, 15, 11, 12'hFFF, "f4_clip_edge"));
        vecs.push_back(mk(0, 0, 0, 0,   4, 14, 12, 12'h000, "f4_clip_v"));

        foreach (vecs[i]) begin
            if (vecs[i].do_set) begin
                small_if.ball_x = 10'(vecs[i].bx);
                small_if.ball_y = 9'(vecs[i].by);
                small_if.winner = 2'(vecs[i].bw);
            end
            advance_to(pix_edge(vecs[i].f, vecs[i].h, vecs[i].v));
            check(vecs[i].name, 32'(small_rgb()), 32'(vecs[i].rgb));
        end

        // Mid-frame reset while both syncs are active.
        advance_to(pix_edge(4, 19, 14));
        check("pre_rst_hsync", 32'(small_if.hsync), 32'd0);
        check("pre_rst_vsync", 32'(small_if.vsync), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_hsync", 32'(small_if.hsync), 32'd1);
        check("mid_rst_vsync", 32'(small_if.vsync), 32'd1);
        check("mid_rst_rgb", 32'(small_rgb()), 32'h000);
        check("mid_rst_tick", 32'(small_if.frame_tick), 32'd0);
        hold_reset();

        // Timing restarts at (0,0) with cleared shadows.
        advance_to(3);
        check("post_rst_pre_pix", 32'(small_rgb()), 32'h000);
        advance_to(4);
        check("post_rst_origin", 32'(small_rgb()), 32'hFFF);

        prev     = small_if.vsync;
        tick1    = -1;
        tick2    = -1;
        tick_cnt = 0;
        vs_low   = 0;
        vs_fall  = -1;
        for (int e = 5; e <= 2890; e++) begin
            advance_to(e);
            if (small_if.frame_tick) begin
                tick_cnt++;
                if (tick1 < 0) tick1 = e;
                else if (tick2 < 0) tick2 = e;
            end
            if (!small_if.vsync) vs_low++;
            if (prev && !small_if.vsync && vs_fall < 0) vs_fall = e;
            prev = small_if.vsync;
        end
        check("tick_first", 32'(tick1), 32'd1156);
        check("tick_period", 32'(tick2), 32'd2884);
        check("tick_width", 32'(tick_cnt), 32'd2);
        check("vsync_fall", 32'(vs_fall), 32'd1348);
        check("vsync_low_clks", 32'(vs_low), 32'd192);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
